// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with internal baud divider and valid/ready input handshake.
// Optional transmit FIFO in front of the state machine is enabled by defining UART_TX_FIFO_EN.
module uart_tx_param #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 tx_clk,
    input  logic                 enable,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 TX,
    output logic                 done,
    output logic                 busy,
    output logic [2:0]           txstate,
    output logic [3:0]           fifo_level
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [15:0]          baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;

    logic                 start_req;
    logic [DATA_BITS-1:0] start_data;
    logic                 bit_end;

    initial begin
        if (DATA_BITS < 5 || DATA_BITS > 9) $error("uart_tx_param: illegal DATA_BITS %0d", DATA_BITS);
        if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 65535)
            $error("uart_tx_param: illegal CLKS_PER_BIT %0d", CLKS_PER_BIT);
        if (PARITY_MODE > 2) $error("uart_tx_param: illegal PARITY_MODE %0d", PARITY_MODE);
        if (STOP_BITS < 1 || STOP_BITS > 2) $error("uart_tx_param: illegal STOP_BITS %0d", STOP_BITS);
        if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
            $error("uart_tx_param: illegal FIFO_DEPTH %0d", FIFO_DEPTH);
    end

`ifdef UART_TX_FIFO_EN
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [3:0]           count_q, count_d;
    logic                 push, pop;

    assign tx_ready   = (count_q != 4'(FIFO_DEPTH)) && !enable;
    assign push       = tx_valid && tx_ready;
    assign pop        = (state_q == StIdle) && (count_q != 4'd0) && !enable;
    assign start_req  = pop;
    assign start_data = mem_q[rd_ptr_q];
    assign fifo_level = count_q;

    // Pointer width matches the power-of-two depth, so increment wraps naturally.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + 4'(push) - 4'(pop);
    end

    always_ff @(posedge tx_clk) begin
        if (enable) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 4'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) mem_q[wr_ptr_q] <= tx_data;
        end
    end
`else
    assign tx_ready   = (state_q == StIdle) && !enable;
    assign start_req  = tx_valid && tx_ready;
    assign start_data = tx_data;
    assign fifo_level = 4'd0;
`endif

    assign bit_end = (baud_q == 16'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        if (state_q != StIdle) baud_d = bit_end ? 16'd0 : baud_q + 16'd1;

        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (start_req) begin
                    state_d = StStart;
                    tx_d    = 1'b0;
                    shift_d = start_data;
                    par_d   = (PARITY_MODE == 2) ? ~^start_data : ^start_data;
                    baud_d  = 16'd0;
                    bit_d   = 4'd0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                    bit_d   = 4'd0;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = {1'b1, shift_q[DATA_BITS-1:1]};
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d = 4'd0;
                        if (PARITY_MODE != 0) begin
                            state_d = StParity;
                            tx_d    = par_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                    bit_d   = 4'd0;
                end
            end
            StStop: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        bit_d   = 4'd0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge tx_clk) begin
        if (enable) begin
            state_q <= StIdle;
            baud_q  <= 16'd0;
            bit_q   <= 4'd0;
            shift_q <= '1;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign TX      = tx_q;
    assign done    = done_q;
    assign busy    = (state_q != StIdle);
    assign txstate = state_q;

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 bit-per-clock transmitter. Adds:
- configurable data width, parity mode and stop-bit count;
- an internal baud divider, so one bit lasts CLKS_PER_BIT clocks;
- a valid/ready input handshake;
- an optional transmit FIFO.

It sits between the byte-producing logic and the serial TX pad, in the same tx_clk domain.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..9.
- CLKS_PER_BIT, 16, tx_clk cycles per serial bit; legal 1..65535.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd; 3 is illegal.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.
- FIFO_DEPTH, 4, FIFO entries; power of 2, 2..8; used only with UART_TX_FIFO_EN.

Ports:
- tx_clk  in  1  clock; all logic is on the rising edge.
- enable  in  1  synchronous, active-high reset.
- tx_valid  in  1  data word offered.
- tx_data  in  DATA_BITS  word to send; sampled when tx_valid && tx_ready.
- tx_ready  out  1  block can accept a word this cycle.
- TX  out  1  serial line, registered; idles high.
- done  out  1  one-cycle pulse at the end of each frame.
- busy  out  1  high while state != IDLE.
- txstate  out  3  current state: 0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP.
- fifo_level  out  4  FIFO occupancy; constant 0 without UART_TX_FIFO_EN.

Behaviour:
- Reset (enable=1 at an edge):
  - Next edge gives state=IDLE, TX=1, done=0, busy=0, baud counter=0, bit counter=0, shift register all ones, fifo_level=0, tx_ready=0.
  - Applies mid-frame: the frame is aborted, TX returns high on that edge, and the FIFO is flushed.
- Handshake:
  - A transfer occurs on an edge where tx_valid && tx_ready.
  - tx_data is captured on that edge.
  - tx_valid without tx_ready is ignored; there is no data loss requirement on the sender side.
- Without FIFO: tx_ready = (state==IDLE) && !enable.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - A bit ends when count == CLKS_PER_BIT-1; the counter then wraps to 0.
- State machine:
  - IDLE: TX=1. On accept, go to START and set TX=0 on the same edge; the shift register loads the data and the parity bit is latched.
  - START: after 1 bit time, go to DATA; TX = data[0].
  - DATA: sends bits LSB first, shifting once per bit end. After DATA_BITS bits, go to PARITY if PARITY_MODE != 0, otherwise go to STOP.
  - PARITY: TX = parity bit for 1 bit time, then go to STOP.
  - STOP: TX=1 for STOP_BITS bit times, then go to IDLE with done=1 for exactly that one cycle.
- Parity:
  - Even: parity bit = XOR of the data bits.
  - Odd: parity bit = inverted XOR of the data bits.
- Frame length: (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) × CLKS_PER_BIT cycles, counted from the accept edge to the edge that enters IDLE.
- Back-to-back: a word may be accepted in the cycle done=1, which gives exactly 1 extra idle-high clock between frames.
- CLKS_PER_BIT=1: every bit lasts one clock and there are no wait cycles.
- Illegal parameter values are flagged by a simulation-time $error in an initial block; they are not synthesised.

Optional Feature:
Macro UART_TX_FIFO_EN.

Defined:
- FIFO_DEPTH-entry synchronous FIFO in front of the state machine.
- tx_ready = !full && !enable.
- Pop occurs when state==IDLE and the FIFO is not empty; the START transition happens on the pop edge. An accept into an empty FIFO therefore reaches TX=0 one cycle later than without the FIFO.
- Push and pop on the same edge: both occur and fifo_level is unchanged.
- Full: tx_ready=0 and no overwrite occurs.
- Pointers wrap modulo FIFO_DEPTH.
- fifo_level reflects the count after each edge.

Undefined:
- No FIFO; single-word behaviour as above.
- fifo_level tied to 0.

Test Plan:
- DATA_BITS=8, CLKS_PER_BIT=4, PARITY_MODE=0, STOP_BITS=1; send 0xA5 → TX sequence 0,1,0,1,0,0,1,0,1,1, each value held 4 clocks; done pulses 40 clocks after accept; busy high for those 40.
- PARITY_MODE=1 then 2, send 0xA5 → parity bit 0 (even) then 1 (odd) in the 10th bit slot; frame 44 clocks.
- STOP_BITS=2, CLKS_PER_BIT=1, tx_valid held high with 0x00 then 0xFF → frames 0,00000000,1,1 and 0,11111111,1,1 with exactly one idle clock between them; tx_ready high only in IDLE cycles.
- Assert enable for 1 cycle mid-DATA on 0x3C → TX=1, state=0, busy=0 on the next edge; the following send of 0x55 completes correctly.
- With UART_TX_FIFO_EN, FIFO_DEPTH=4: push 5 words back-to-back → tx_ready drops after fifo_level reaches 4 (one word already popped); all words are transmitted in order with correct fifo_level decrement on each pop.
- With UART_TX_FIFO_EN, push on the same edge as a pop → fifo_level unchanged and no word lost.
